// File: rtl/envelope_detector_pkg.sv
// Shared definitions for the envelope detector: FSM states and root sizing.
package envelope_detector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SQUARE = 3'd2,
        ST_ROOT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 18;

    // One root bit per ROOT cycle; the root is as wide as a complex input.
    function automatic int unsigned root_iters(input int unsigned data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/envelope_detector_if.sv
// Sample-in / magnitude-out signal bundle for envelope_detector.
interface envelope_detector_if
    import envelope_detector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                      enable;
    logic                      stopDataInFlag;
    logic                      dataInValid;
    logic [2*DATA_WIDTH-1:0]   dataInRe;
    logic [2*DATA_WIDTH-1:0]   dataInIm;
    logic                      dataInReady;
    logic [2*DATA_WIDTH-1:0]   dataOut;
    logic                      dataOutValid;

    modport master (
        output enable, stopDataInFlag, dataInValid, dataInRe, dataInIm,
        input  dataInReady, dataOut, dataOutValid
    );

    modport slave (
        input  enable, stopDataInFlag, dataInValid, dataInRe, dataInIm,
        output dataInReady, dataOut, dataOutValid
    );

endinterface

// File: rtl/envelope_detector_isqrt_serial.sv
// Serial digit-by-digit integer square root, one result bit per cycle, MSB first.
module isqrt_serial #(
    parameter int unsigned ROOT_W = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*ROOT_W-1:0]   radicand,
    output logic [ROOT_W-1:0]     root,
    output logic                  done
);
    localparam int unsigned CW = $clog2(ROOT_W);
    localparam int unsigned RW = ROOT_W + 2;

    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [RW+1:0]     rem_shift;
    logic [RW+1:0]     trial;

    // Radicand must stay stable from the cycle after start until done.
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        root_d    = root_q;
        rem_shift = {rem_q, radicand[2*int'(cnt_q) +: 2]};
        trial     = {2'b00, root_q, 2'b01};
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(ROOT_W - 1);
            rem_d  = '0;
            root_d = '0;
        end else if (busy_q) begin
            if (rem_shift >= trial) begin
                rem_d  = RW'(rem_shift - trial);
                root_d = {root_q[ROOT_W-2:0], 1'b1};
            end else begin
                rem_d  = RW'(rem_shift);
                root_d = {root_q[ROOT_W-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            root_q <= root_d;
        end
    end

    // Asserted during the final iteration so the caller can leave ROOT on time.
    assign done = busy_q && (cnt_q == '0);
    assign root = root_q;

endmodule

// File: rtl/envelope_detector.sv
// Magnitude detector: floor(sqrt(Re^2 + Im^2)) of a complex sample, one at a time.
module envelope_detector
    import envelope_detector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic                clock,
    input logic                reset,
    envelope_detector_if.slave bus
);
    localparam int unsigned SW = root_iters(DATA_WIDTH);
    localparam int unsigned QW = 2 * SW;

    state_e                state_q, state_d;
    logic signed [SW-1:0]  re_q, re_d;
    logic signed [SW-1:0]  im_q, im_d;
    logic [QW-1:0]         sum_q, sum_d;
    logic [SW-1:0]         dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  stop_lat_q, stop_lat_d;
    logic                  dis_lat_q, dis_lat_d;
    logic signed [QW-1:0]  re_sq, im_sq;
    logic                  root_start;
    logic                  root_done;
    logic [SW-1:0]         root;

    // Full-width signed squares: exact even for the most negative input.
    assign re_sq = QW'(re_q) * QW'(re_q);
    assign im_sq = QW'(im_q) * QW'(im_q);

    always_comb begin
        state_d    = state_q;
        re_d       = re_q;
        im_d       = im_q;
        sum_d      = sum_q;
        dout_d     = dout_q;
        dvalid_d   = 1'b0;
        stop_lat_d = stop_lat_q;
        dis_lat_d  = dis_lat_q;
        root_start = 1'b0;

        if (state_q inside {ST_SQUARE, ST_ROOT, ST_DONE}) begin
            if (bus.stopDataInFlag) stop_lat_d = 1'b1;
            if (!bus.enable)        dis_lat_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                stop_lat_d = 1'b0;
                dis_lat_d  = 1'b0;
                if (bus.stopDataInFlag || stop_lat_q) begin
                    state_d = ST_STOP;
                end else if (!bus.enable || dis_lat_q) begin
                    state_d = ST_IDLE;
                end else if (bus.dataInValid) begin
                    re_d    = $signed(bus.dataInRe);
                    im_d    = $signed(bus.dataInIm);
                    state_d = ST_SQUARE;
                end
            end
            ST_SQUARE: begin
                sum_d      = $unsigned(re_sq) + $unsigned(im_sq);
                root_start = 1'b1;
                state_d    = ST_ROOT;
            end
            ST_ROOT: begin
                if (root_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                dout_d   = root;
                dvalid_d = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_STOP: begin
                dout_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                re_d       = '0;
                im_d       = '0;
                sum_d      = '0;
                dout_d     = '0;
                stop_lat_d = 1'b0;
                dis_lat_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            re_q       <= '0;
            im_q       <= '0;
            sum_q      <= '0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            stop_lat_q <= 1'b0;
            dis_lat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            re_q       <= re_d;
            im_q       <= im_d;
            sum_q      <= sum_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            stop_lat_q <= stop_lat_d;
            dis_lat_q  <= dis_lat_d;
        end
    end

    isqrt_serial #(
        .ROOT_W (SW)
    ) u_isqrt (
        .clk      (clock),
        .rst      (reset),
        .start    (root_start),
        .radicand (sum_q),
        .root     (root),
        .done     (root_done)
    );

    assign bus.dataInReady  = (state_q == ST_WAIT);
    assign bus.dataOut      = dout_q;
    assign bus.dataOutValid = dvalid_q;

endmodule

// File: doc/envelope_detector.md
ENVELOPE_DETECTOR -- requirements
Module: envelope_detector

Interface
REQ-001 Parameter DATA_WIDTH, default 18, is the base sample width; complex inputs are 2*DATA_WIDTH bits.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  high to leave IDLE and process samples.
REQ-005 stopDataInFlag  input  1  high ends the data stream.
REQ-006 dataInValid  input  1  dataInRe/dataInIm hold a valid sample this cycle.
REQ-007 dataInRe  input  2*DATA_WIDTH  signed in-phase sample, the direct path of the analytic signal.
REQ-008 dataInIm  input  2*DATA_WIDTH  signed quadrature sample, the Hilbert path of the analytic signal.
REQ-009 dataInReady  output  1  high only in WAIT; a sample transfers on an edge where dataInValid and dataInReady are both high.
REQ-010 dataOut  output  2*DATA_WIDTH  unsigned magnitude floor(sqrt(Re^2+Im^2)).
REQ-011 dataOutValid  output  1  one-cycle pulse marking a new dataOut.

Function
REQ-012 FSM states: IDLE, WAIT, SQUARE, ROOT, DONE, STOP.
REQ-013 IDLE: dataInReady=0; enable high -> WAIT on next edge.
REQ-014 WAIT: dataInReady=1; priority stopDataInFlag -> STOP, then !enable -> IDLE, then transfer -> SQUARE with Re/Im captured.
REQ-015 SQUARE: one cycle; register sum S = Re*Re + Im*Im as 4*DATA_WIDTH-bit unsigned; no overflow is possible, including Re=Im=-2^(2*DATA_WIDTH-1).
REQ-016 ROOT: exactly 2*DATA_WIDTH cycles of digit-by-digit integer square root, one result bit per cycle, MSB first, down-counter from 2*DATA_WIDTH-1 to 0.
REQ-017 Root is floor(sqrt(S)); the result always fits 2*DATA_WIDTH unsigned bits.
REQ-018 DONE: one cycle; registers the root to dataOut and pulses dataOutValid; goes to WAIT.
REQ-019 Latency: sample transferred on edge E0 -> dataOutValid high during the cycle after edge E0+38, for DATA_WIDTH=18; generally E0+2*DATA_WIDTH+2.
REQ-020 Throughput: one sample per 2*DATA_WIDTH+3 cycles; back-to-back transfers are accepted immediately on return to WAIT.
REQ-021 dataOut holds its last value between pulses; dataOutValid is 0 in every cycle other than DONE.
REQ-022 stopDataInFlag or enable deasserted during SQUARE/ROOT/DONE: the in-flight sample completes and its pulse is emitted; the flag is latched and acted on in WAIT.
REQ-023 A stop latched during processing takes priority over a latched !enable.
REQ-024 STOP: dataInReady=0, dataOut=0, dataOutValid=0; terminal until reset.
REQ-025 dataInValid is ignored outside WAIT; input values are don't-care when no transfer occurs.
REQ-026 Unknown state encoding -> IDLE with all registers cleared.

Reset
REQ-027 reset high on an edge -> state IDLE, dataOut=0, dataOutValid=0, dataInReady=0, counter and latched flags cleared, in-flight sample discarded with no pulse.
REQ-028 Reset has priority over every other input in every state.

Structure
REQ-029 A shared package holds the FSM state encodings and the ROOT iteration count, 2*DATA_WIDTH.
REQ-030 One sub-module, isqrt_serial, implements the iterative root with a start/done handshake.
REQ-031 The squaring and the FSM stay in envelope_detector.

Verification
REQ-032 Re=3, Im=4 transferred at E0 -> dataOut=5, dataOutValid pulsed after E0+38 only.
REQ-033 Re=-5, Im=12 -> 13; Re=1, Im=1 -> 1; Re=0, Im=0 -> 0, with the pulse still emitted.
REQ-034 Re=Im=-2^35 -> dataOut=floor(2^35*sqrt2)=48592007999, with no overflow.
REQ-035 dataInValid held high with 3 distinct samples -> 3 pulses 39 cycles apart, with results in order.
REQ-036 stopDataInFlag pulsed mid-ROOT -> current result pulsed, then STOP with dataInReady=0 permanently; reset returns the block to IDLE.
REQ-037 reset asserted mid-ROOT -> no dataOutValid pulse, and dataOut=0 on the next cycle.
